// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline stages and the unified
// memory port arbiter.
package mips_pkg;

    localparam int unsigned MIPS_ADDR_W = 32;
    localparam int unsigned MIPS_DATA_W = 32;

    localparam logic [31:0] ARB_POISON = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port arbiter.
// master: the IF/MEM stages plus the memory array; slave: the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              stall;
    logic              err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata,
               mem_rdata, mem_valid,
        input  if_rdata, if_ready, d_rdata, d_ready, stall, err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata,
               mem_rdata, mem_valid,
        output if_rdata, if_ready, d_rdata, d_ready, stall, err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_wait_timer.sv
// Per-access wait counter: restarts on grant, counts busy cycles and flags
// expiry once TIMEOUT-1 cycles have passed without a memory answer.
module arb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(TIMEOUT - 1));
    assign expire = run & at_max;

    always_comb begin
        cnt_d = cnt_q;
        if (start || clear) begin
            cnt_d = '0;
        end else if (run && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with data priority, fetch anti-starvation and a per-access timeout.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W      = MIPS_ADDR_W,
    parameter int unsigned DATA_W      = MIPS_DATA_W,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned MAX_D_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BW = $clog2(MAX_D_BURST + 1);

    arb_state_t        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [BW-1:0]     burst_q, burst_d;

    logic              data_req;
    logic              data_ok;
    logic              grant;
    logic              done;
    logic              expire;
    logic [DATA_W-1:0] ret_data;

    assign data_req = bus.d_read | bus.d_write;
    // Fetch gets the port once MAX_D_BURST data grants were made while it waited.
    assign data_ok  = data_req & ~(bus.if_req & (burst_q == BW'(MAX_D_BURST)));

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (grant),
        .run    (state_q != IDLE),
        .clear  (done),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        burst_d     = burst_q;
        grant       = 1'b0;
        done        = 1'b0;
        ret_data    = '0;

        case (state_q)
            IDLE: begin
                if (data_ok) begin
                    state_d     = DATA;
                    grant       = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_write;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    burst_d     = bus.if_req ? burst_q + BW'(1) : '0;
                end else if (bus.if_req) begin
                    state_d     = INSTR;
                    grant       = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    burst_d     = '0;
                end
            end
            DATA, INSTR: begin
                // A memory answer in the expiry cycle still counts as success.
                if (bus.mem_valid || expire) begin
                    done     = 1'b1;
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (bus.mem_valid) begin
                        ret_data = mem_we_q ? '0 : bus.mem_rdata;
                    end else begin
                        ret_data = DATA_W'(ARB_POISON);
                        err_d    = 1'b1;
                    end
                    if (state_q == DATA) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = ret_data;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = ret_data;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            burst_q     <= burst_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.stall     = (data_req & ~d_ready_q) | (bus.if_req & ~if_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-latency memory answers driven
// step by step, every expected value written out by hand.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT     (16),
        .MAX_D_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_addr [6];
    logic        exp_instr [6];

    initial begin
        int d_idx;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
        chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        rst_n = 1'b1;
        step();

        // Lone fetch, memory answers in the third mem_en cycle
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        #1;
        chk("f_stall_req", 64'(bus.stall), 64'd1);
        step();
        chk("f_en1", 64'(bus.mem_en), 64'd1);
        chk("f_addr", 64'(bus.mem_addr), 64'h10);
        chk("f_we", 64'(bus.mem_we), 64'd0);
        step();
        chk("f_en2", 64'(bus.mem_en), 64'd1);
        step();
        chk("f_en3", 64'(bus.mem_en), 64'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hABCD;
        step();
        bus.mem_valid = 1'b0;
        chk("f_ready", 64'(bus.if_ready), 64'd1);
        chk("f_rdata", 64'(bus.if_rdata), 64'hABCD);
        chk("f_en_off", 64'(bus.mem_en), 64'd0);
        chk("f_stall_rdy", 64'(bus.stall), 64'd0);
        bus.if_req = 1'b0;
        step();
        chk("f_ready_pulse", 64'(bus.if_ready), 64'd0);
        chk("f_stall_after", 64'(bus.stall), 64'd0);
        chk("f_no_regrant", 64'(bus.mem_en), 64'd0);

        // Contention: data first, fetch next
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h8;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        step();
        chk("c_d_addr", 64'(bus.mem_addr), 64'h8);
        chk("c_stall1", 64'(bus.stall), 64'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h1111;
        step();
        bus.mem_valid = 1'b0;
        chk("c_d_ready", 64'(bus.d_ready), 64'd1);
        chk("c_d_rdata", 64'(bus.d_rdata), 64'h1111);
        chk("c_if_ready0", 64'(bus.if_ready), 64'd0);
        chk("c_stall2", 64'(bus.stall), 64'd1);
        bus.d_read = 1'b0;
        step();
        chk("c_i_en", 64'(bus.mem_en), 64'd1);
        chk("c_i_addr", 64'(bus.mem_addr), 64'h20);
        chk("c_stall3", 64'(bus.stall), 64'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h2222;
        step();
        bus.mem_valid = 1'b0;
        chk("c_if_ready", 64'(bus.if_ready), 64'd1);
        chk("c_if_rdata", 64'(bus.if_rdata), 64'h2222);
        chk("c_d_ready0", 64'(bus.d_ready), 64'd0);
        bus.if_req = 1'b0;
        step();

        // Anti-starvation: 4 data grants, 1 fetch, then the 5th data grant
        exp_addr[0] = 32'h100; exp_instr[0] = 1'b0;
        exp_addr[1] = 32'h104; exp_instr[1] = 1'b0;
        exp_addr[2] = 32'h108; exp_instr[2] = 1'b0;
        exp_addr[3] = 32'h10C; exp_instr[3] = 1'b0;
        exp_addr[4] = 32'h40;  exp_instr[4] = 1'b1;
        exp_addr[5] = 32'h110; exp_instr[5] = 1'b0;
        d_idx       = 0;
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h100;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        for (int s = 0; s < 6; s++) begin
            step();
            chk($sformatf("s%0d_en", s), 64'(bus.mem_en), 64'd1);
            chk($sformatf("s%0d_addr", s), 64'(bus.mem_addr), 64'(exp_addr[s]));
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 32'h5000 + 32'(s);
            step();
            bus.mem_valid = 1'b0;
            if (exp_instr[s]) begin
                chk($sformatf("s%0d_if_ready", s), 64'(bus.if_ready), 64'd1);
                chk($sformatf("s%0d_if_rdata", s), 64'(bus.if_rdata), 64'h5000 + 64'(s));
                bus.if_req = 1'b0;
            end else begin
                chk($sformatf("s%0d_d_ready", s), 64'(bus.d_ready), 64'd1);
                chk($sformatf("s%0d_d_rdata", s), 64'(bus.d_rdata), 64'h5000 + 64'(s));
                d_idx++;
                if (d_idx < 5) bus.d_addr = 32'h100 + 32'(4 * d_idx);
                else bus.d_read = 1'b0;
            end
        end
        step();

        // Store: request registered and held until mem_valid
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h4;
        bus.d_wdata = 32'h55;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("st%0d_we", c), 64'(bus.mem_we), 64'd1);
            chk($sformatf("st%0d_addr", c), 64'(bus.mem_addr), 64'h4);
            chk($sformatf("st%0d_wdata", c), 64'(bus.mem_wdata), 64'h55);
            chk($sformatf("st%0d_en", c), 64'(bus.mem_en), 64'd1);
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h9999;
        step();
        bus.mem_valid = 1'b0;
        chk("st_ready", 64'(bus.d_ready), 64'd1);
        chk("st_rdata", 64'(bus.d_rdata), 64'd0);
        chk("st_we_off", 64'(bus.mem_we), 64'd0);
        bus.d_write = 1'b0;
        step();

        // Read and write together: treated as a store
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h24;
        bus.d_wdata = 32'h77;
        step();
        chk("rw_we", 64'(bus.mem_we), 64'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h3333;
        step();
        bus.mem_valid = 1'b0;
        chk("rw_ready", 64'(bus.d_ready), 64'd1);
        chk("rw_rdata", 64'(bus.d_rdata), 64'd0);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        step();

        // mem_valid while idle is ignored
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h4444;
        step();
        bus.mem_valid = 1'b0;
        chk("idle_d_ready", 64'(bus.d_ready), 64'd0);
        chk("idle_if_ready", 64'(bus.if_ready), 64'd0);
        chk("idle_err", 64'(bus.err), 64'd0);

        // Timeout abort after 16 mem_en cycles
        bus.d_read = 1'b1;
        bus.d_addr = 32'hC;
        step();
        repeat (15) step();
        chk("to_en_last", 64'(bus.mem_en), 64'd1);
        chk("to_ready_early", 64'(bus.d_ready), 64'd0);
        step();
        chk("to_ready", 64'(bus.d_ready), 64'd1);
        chk("to_rdata", 64'(bus.d_rdata), 64'hDEADBEEF);
        chk("to_err", 64'(bus.err), 64'd1);
        chk("to_en_off", 64'(bus.mem_en), 64'd0);
        bus.d_read = 1'b0;
        step();
        chk("to_err_sticky", 64'(bus.err), 64'd1);
        chk("to_ready_pulse", 64'(bus.d_ready), 64'd0);

        // Reset in the middle of a data access
        bus.d_read = 1'b1;
        bus.d_addr = 32'h18;
        step();
        chk("rm_en", 64'(bus.mem_en), 64'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rm_en_off", 64'(bus.mem_en), 64'd0);
        chk("rm_err_clr", 64'(bus.err), 64'd0);
        chk("rm_d_ready", 64'(bus.d_ready), 64'd0);
        chk("rm_addr_clr", 64'(bus.mem_addr), 64'd0);
        chk("rm_stall", 64'(bus.stall), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rm_regrant_en", 64'(bus.mem_en), 64'd1);
        chk("rm_regrant_addr", 64'(bus.mem_addr), 64'h18);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h6666;
        step();
        bus.mem_valid = 1'b0;
        chk("rm_ready", 64'(bus.d_ready), 64'd1);
        chk("rm_rdata", 64'(bus.d_rdata), 64'h6666);
        bus.d_read = 1'b0;
        step();

        // mem_valid in the expiry cycle wins over the timeout
        bus.d_read = 1'b1;
        bus.d_addr = 32'h14;
        step();
        repeat (15) step();
        chk("ex_en_last", 64'(bus.mem_en), 64'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h7777;
        step();
        bus.mem_valid = 1'b0;
        chk("ex_ready", 64'(bus.d_ready), 64'd1);
        chk("ex_rdata", 64'(bus.d_rdata), 64'h7777);
        chk("ex_err", 64'(bus.err), 64'd0);
        bus.d_read = 1'b0;
        step();
        chk("ex_err_after", 64'(bus.err), 64'd0);
        chk("ex_en_off", 64'(bus.mem_en), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
